// File: rtl/debounce_pkg.sv
// Shared types and constants for the switch synchroniser/debouncer.
// Each channel steps through the four states declared here.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        PEND_HI   = 2'b01,
        STABLE_HI = 2'b10,
        PEND_LO   = 2'b11
    } state_e;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_chan.sv
// Single-channel debounce FSM: one synchronised bit in, registered level plus
// one-cycle rise/fall pulses out.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_in,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Next-state logic; the counter clears unless a pending state advances it.
    always_comb begin
        state_d = state_q;
        cnt_d   = CNT_ZERO;
        db_d    = db_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (sync_in) begin
                    state_d = PEND_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = STABLE_LO;
                end
            end
            PEND_HI: begin
                if (!sync_in) begin
                    state_d = STABLE_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    db_d    = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!sync_in) begin
                    state_d = PEND_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = STABLE_HI;
                end
            end
            PEND_LO: begin
                if (sync_in) begin
                    state_d = STABLE_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    db_d    = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                db_d    = 1'b0;
            end
        endcase
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= STABLE_LO;
            cnt_q   <= CNT_ZERO;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign db   = db_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/switch_debounce.sv
// N-channel switch conditioner: a shared two-flop synchroniser feeding one
// independent debounce FSM per channel.
module switch_debounce
    import debounce_pkg::*;
#(
    parameter int N               = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [N-1:0] SW,
    output logic [N-1:0] DB,
    output logic [N-1:0] RISE,
    output logic [N-1:0] FALL
);

    logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;

    // Shift the raw switch levels through the synchroniser stages.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = SW;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Synchroniser flops, cleared on reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync_q <= {(SYNC_STAGES*N){1'b0}};
        end else begin
            sync_q <= sync_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk    (CLK),
            .rst_n  (RST_N),
            .sync_in(sync_q[SYNC_STAGES-1][i]),
            .db     (DB[i]),
            .rise   (RISE[i]),
            .fall   (FALL[i])
        );
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce (N=2, DEBOUNCE_CYCLES=4): a run-length
// model checked every cycle, plus hand-computed literal expectations.
module tb_switch_debounce;

    localparam int N  = 2;
    localparam int DC = 4;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic [N-1:0] SW;
    logic [N-1:0] DB, RISE, FALL;

    int errors = 0;
    int checks = 0;

    switch_debounce #(.N(N), .DEBOUNCE_CYCLES(DC)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .SW   (SW),
        .DB   (DB),
        .RISE (RISE),
        .FALL (FALL)
    );

    always #5 CLK = ~CLK;

    // Model: two-cycle delay line, then a level flips once the delayed input
    // has disagreed with it for DC consecutive edges.
    logic [N-1:0] m_s1, m_s2, m_db, m_rise, m_fall;
    int           m_run [N];
    bit           started = 1'b0;

    initial begin
        forever begin
            @(posedge CLK);
            if (!RST_N) begin
                m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
                for (int i = 0; i < N; i++) m_run[i] = 0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    m_rise[i] = 1'b0;
                    m_fall[i] = 1'b0;
                    if (m_s2[i] != m_db[i]) begin
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] == DC) begin
                            m_db[i]   = m_s2[i];
                            m_rise[i] = m_s2[i];
                            m_fall[i] = ~m_s2[i];
                            m_run[i]  = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
                m_s2 = m_s1;
                m_s1 = SW;
            end
            started = 1'b1;
        end
    end

    task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (started) begin
                cmp("model_db", DB, m_db);
                cmp("model_rise", RISE, m_rise);
                cmp("model_fall", FALL, m_fall);
            end
        end
    end

    task automatic lit(input string name, input logic [N-1:0] db,
                       input logic [N-1:0] rise, input logic [N-1:0] fall);
        checks++;
        if ({DB, RISE, FALL} !== {db, rise, fall}) begin
            errors++;
            $display("FAIL %s at %0t: got DB=%b RISE=%b FALL=%b, expected DB=%b RISE=%b FALL=%b",
                     name, $time, DB, RISE, FALL, db, rise, fall);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        SW    = 2'b11;
        RST_N = 1'b0;
        step(3);
        lit("reset", 2'b00, 2'b00, 2'b00);

        // release with both switches held high: rise at k+5
        RST_N = 1'b1;
        step(5); lit("rel_wait", 2'b00, 2'b00, 2'b00);
        step(1); lit("rel_rise", 2'b11, 2'b11, 2'b00);
        step(1); lit("rel_rise_end", 2'b11, 2'b00, 2'b00);

        SW = 2'b00;
        step(5); lit("both_fall_wait", 2'b11, 2'b00, 2'b00);
        step(1); lit("both_fall", 2'b00, 2'b00, 2'b11);
        step(1); lit("both_fall_end", 2'b00, 2'b00, 2'b00);

        // clean press on channel 0
        SW = 2'b01;
        step(5); lit("press_wait", 2'b00, 2'b00, 2'b00);
        step(1); lit("press_rise", 2'b01, 2'b01, 2'b00);
        step(1); lit("press_end", 2'b01, 2'b00, 2'b00);

        // three-cycle glitch on channel 1 is rejected
        SW = 2'b11;
        step(3);
        SW = 2'b01;
        step(8); lit("glitch", 2'b01, 2'b00, 2'b00);

        SW = 2'b00;
        step(5); lit("ch0_fall_wait", 2'b01, 2'b00, 2'b00);
        step(1); lit("ch0_fall", 2'b00, 2'b00, 2'b01);
        step(1); lit("ch0_fall_end", 2'b00, 2'b00, 2'b00);

        // bounce: 1,1,1,0 then held 1; count restarts from the last rise
        SW = 2'b01; step(3);
        SW = 2'b00; step(1);
        SW = 2'b01;
        step(5); lit("bounce_wait", 2'b00, 2'b00, 2'b00);
        step(1); lit("bounce_rise", 2'b01, 2'b01, 2'b00);
        step(1); lit("bounce_end", 2'b01, 2'b00, 2'b00);

        // simultaneous opposite transitions
        SW = 2'b10;
        step(5); lit("opp_wait", 2'b01, 2'b00, 2'b00);
        step(1); lit("opp_edge", 2'b10, 2'b10, 2'b01);
        step(1); lit("opp_end", 2'b10, 2'b00, 2'b00);

        // reset while channel 0 is at its last count
        SW = 2'b11;
        step(5); lit("pend_wait", 2'b10, 2'b00, 2'b00);
        RST_N = 1'b0;
        step(1); lit("pend_reset", 2'b00, 2'b00, 2'b00);
        RST_N = 1'b1;
        step(5); lit("pend_rel_wait", 2'b00, 2'b00, 2'b00);
        step(1); lit("pend_rel_rise", 2'b11, 2'b11, 2'b00);
        step(1); lit("pend_rel_end", 2'b11, 2'b00, 2'b00);

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
